ps2_kbd: RTL and testbench
==========================

# ps2_kbd

Consumes completed PS/2 scan-code-set-2 bytes from the PS/2 receiver and turns them into a stream of ASCII characters for the terminal core. It tracks prefix bytes, Shift/Ctrl/Caps-Lock state and break codes. Decoded characters go into a small first-word-fall-through FIFO drained by a valid/ready handshake. It sits between the PS/2 receiver and the terminal's host-transmit path.

## Interface

- `FIFO_DEPTH`, default 4: FIFO entries; power of two, minimum 4.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `rx_data`  in  8  byte from the PS/2 receiver; valid while `rx_done` is high.
- `rx_done`  in  1  level from the receiver; a low→high transition marks one new byte. It may stay high for many cycles.
- `key_data`  out  8  ASCII character at the FIFO head.
- `key_valid`  out  1  FIFO not empty.
- `key_ready`  in  1  consumer accepts the head character.
- `shift`  out  1  either Shift key held.
- `ctrl`  out  1  either Ctrl key held.
- `caps`  out  1  Caps-Lock toggle state.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation

- **Byte strobe:** register `rx_done`. A byte is taken when `rx_done`=1 and its registered copy is 0. It is taken exactly once, however long `rx_done` stays high.
- **Decoder FSM states:** IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen), SKIP (E1 seen).
- **Transitions from IDLE:**
  - E0→EXT; F0→BRK; E1→SKIP with a skip counter of 7.
  - 00, AA, EE, FA, FC, FE, FF are ignored and stay in IDLE.
  - Any other byte is a make code: process it, stay in IDLE.
- **Transitions from EXT:** F0→EXTBRK; any other byte is an extended make, processed, then →IDLE.
- **BRK / EXTBRK:** the next byte is a break code, processed, then →IDLE.
- **SKIP:** decrement the counter on each byte; →IDLE when it reaches 0. This swallows the whole Pause sequence.
- **Modifiers:**
  - Make/break of 12 or 59 sets/clears `lshift`/`rshift`; `shift` = OR of the two.
  - Make/break of 14, or of E0 14, sets/clears `lctrl`/`rctrl`; `ctrl` = OR of the two.
  - Caps-Lock (58): `caps` toggles on a make only when `caps_held`=0; then `caps_held` is set. The break clears `caps_held`, so typematic repeats do not toggle.
- **Translation of non-extended makes:**
  - Letters (1C, 32, 21, …, 1A): lower case; upper case when `shift` XOR `caps`.
  - Digits and punctuation (0E, 16–46, 4E, 55, 54, 5B, 5D, 4C, 52, 41, 49, 4A): US layout; the shifted glyph when `shift`=1. `caps` has no effect on these.
  - Fixed keys: 29→20, 5A→0D, 66→08, 0D→09, 76→1B, E0 5A→0D.
  - If `ctrl`=1 and the character is in 40–7F, push `char & 1F`.
  - Unmapped codes push nothing.
- **FIFO:**
  - Pushes happen at the tail. `key_data` always shows the head entry.
  - A pop occurs when `key_valid` and `key_ready` are both high.
  - Push when full without a simultaneous pop: the character is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both take effect.
  - `overflow` clears only on reset.
  - Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits wide, wrapping naturally.

## Timing

- **Reset values:** `key_valid`=0, `key_data`=00, `shift`=`ctrl`=`caps`=0, `overflow`=0. FSM returns to IDLE and all FIFO storage is cleared.
- **Reset mid-sequence** discards any partial prefix.
- **Latency:** `rx_done` sampled high at edge k (low at k−1). Decoding and push happen at edge k+1. `key_valid` is high after edge k+1. Modifier outputs update after edge k+1.
- **Handshake:** the head advances at the edge where `key_valid`&`key_ready`=1. A new head (if any) is visible after that edge. `key_valid` does not drop for a full cycle between back-to-back entries.
- **Rate:** one byte is accepted per `rx_done` rising edge, with no backpressure to the receiver.

## Configuration

- **`PS2_KBD_ARROW_EN` defined:** E0 75/72/74/6B (up, down, right, left) push the three-byte ANSI sequence 1B 5B 41/42/43/44.
  - The bytes are pushed on edges k+1, k+2 and k+3.
  - The sequence is pushed whole only if at least 3 entries are free at edge k+1. Otherwise none of it is pushed and `overflow` is set.
  - A byte arriving during the sequence is still captured and decoded after it.
- **Not defined:** these codes push nothing, and the decoder never needs more than one push per byte.

## Test plan

- **Letter key:** after reset, send 1C, F0 1C with `key_ready`=1 → one character 61, `key_valid` high for exactly one cycle, then nothing more.
- **Shift and Ctrl:**
  - 12, 1C, F0 1C, F0 12 → 41, and `shift` is 1 between 12 and F0 12.
  - 14, 21 → 03.
- **Caps-Lock:** 58, 58, 58 (typematic), F0 58, 1C → `caps`=1 with one toggle only, character 41.
- **FIFO overflow:** hold `key_ready`=0 and send 5 makes of 29 with `FIFO_DEPTH`=4 → `key_valid`=1 and `overflow`=1. Then raise `key_ready` → exactly four 20 characters.
- **Pause and extended break:** send E1 14 77 E1 F0 14 F0 77, then 1C → only 61 is output. Then E0 14, E0 F0 14 → `ctrl` goes 1 then 0.
- **Arrow key:**
  - With `PS2_KBD_ARROW_EN`: E0 75 → 1B 5B 41 on consecutive pops.
  - Without it: nothing is output.

Source files
------------

// File: rtl/ps2_kbd_if.sv
// Byte input from the PS/2 receiver, character output handshake and keyboard status flags.
// The decoder takes the slave modport; the receiver/terminal side takes the master modport.
interface ps2_kbd_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready;
    logic       shift;
    logic       ctrl;
    logic       caps;
    logic       overflow;

    modport slave (
        input  rx_data, rx_done, key_ready,
        output key_data, key_valid, shift, ctrl, caps, overflow
    );

    modport master (
        output rx_data, rx_done, key_ready,
        input  key_data, key_valid, shift, ctrl, caps, overflow
    );
endinterface

// File: rtl/ps2_kbd.sv
// PS/2 scan-code-set-2 decoder: prefix/modifier tracking, US ASCII translation, FWFT output FIFO.
// Define PS2_KBD_ARROW_EN to emit ANSI escape sequences (ESC [ A..D) for the arrow keys.
module ps2_kbd #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    ps2_kbd_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

    state_e      r_state, w_state_d;
    logic        r_rx_done, r_byte_vld, w_take, w_busy;
    logic [7:0]  r_byte;
    logic [2:0]  r_skip, w_skip_d;
    logic        w_evt, w_ext, w_brk;
    logic        r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps, r_caps_held;
    logic        w_lshift_d, w_rshift_d, w_lctrl_d, w_rctrl_d, w_caps_d, w_caps_held_d;
    logic        w_shift, w_ctrl, w_upper;
    logic [17:0] w_xl;
    logic [7:0]  w_glyph, w_char, w_push_data;
    logic        w_push, w_ovf_set;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr, w_count;
    logic        r_overflow, w_valid, w_full, w_pop, w_wr;

`ifdef PS2_KBD_ARROW_EN
    localparam logic [AW:0] SEQ_LEN = (AW + 1)'(3);
    logic [1:0] r_seq_cnt, w_seq_cnt_d;
    logic [7:0] r_seq_last, w_seq_last_d;
    assign w_busy = (r_seq_cnt != 2'd0);
`else
    assign w_busy = 1'b0;
`endif

    // Returns {mapped, is_letter, unshifted glyph, shifted glyph}.
    function automatic logic [17:0] f_xlate(input logic [7:0] code);
        logic [17:0] v;
        v = '0;
        case (code)
            8'h1C: v = {2'b11, "a", "A"};       8'h32: v = {2'b11, "b", "B"};
            8'h21: v = {2'b11, "c", "C"};       8'h23: v = {2'b11, "d", "D"};
            8'h24: v = {2'b11, "e", "E"};       8'h2B: v = {2'b11, "f", "F"};
            8'h34: v = {2'b11, "g", "G"};       8'h33: v = {2'b11, "h", "H"};
            8'h43: v = {2'b11, "i", "I"};       8'h3B: v = {2'b11, "j", "J"};
            8'h42: v = {2'b11, "k", "K"};       8'h4B: v = {2'b11, "l", "L"};
            8'h3A: v = {2'b11, "m", "M"};       8'h31: v = {2'b11, "n", "N"};
            8'h44: v = {2'b11, "o", "O"};       8'h4D: v = {2'b11, "p", "P"};
            8'h15: v = {2'b11, "q", "Q"};       8'h2D: v = {2'b11, "r", "R"};
            8'h1B: v = {2'b11, "s", "S"};       8'h2C: v = {2'b11, "t", "T"};
            8'h3C: v = {2'b11, "u", "U"};       8'h2A: v = {2'b11, "v", "V"};
            8'h1D: v = {2'b11, "w", "W"};       8'h22: v = {2'b11, "x", "X"};
            8'h35: v = {2'b11, "y", "Y"};       8'h1A: v = {2'b11, "z", "Z"};
            8'h16: v = {2'b10, "1", "!"};       8'h1E: v = {2'b10, "2", "@"};
            8'h26: v = {2'b10, "3", "#"};       8'h25: v = {2'b10, "4", 8'h24};
            8'h2E: v = {2'b10, "5", 8'h25};     8'h36: v = {2'b10, "6", "^"};
            8'h3D: v = {2'b10, "7", "&"};       8'h3E: v = {2'b10, "8", "*"};
            8'h46: v = {2'b10, "9", "("};       8'h45: v = {2'b10, "0", ")"};
            8'h0E: v = {2'b10, 8'h60, "~"};     8'h4E: v = {2'b10, "-", "_"};
            8'h55: v = {2'b10, "=", "+"};       8'h54: v = {2'b10, "[", "{"};
            8'h5B: v = {2'b10, "]", "}"};       8'h5D: v = {2'b10, 8'h5C, 8'h7C};
            8'h4C: v = {2'b10, ";", ":"};       8'h52: v = {2'b10, 8'h27, 8'h22};
            8'h41: v = {2'b10, ",", "<"};       8'h49: v = {2'b10, ".", ">"};
            8'h4A: v = {2'b10, "/", "?"};       8'h29: v = {2'b10, 8'h20, 8'h20};
            8'h5A: v = {2'b10, 8'h0D, 8'h0D};   8'h66: v = {2'b10, 8'h08, 8'h08};
            8'h0D: v = {2'b10, 8'h09, 8'h09};   8'h76: v = {2'b10, 8'h1B, 8'h1B};
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_take  = r_byte_vld & ~w_busy;
    assign w_shift = r_lshift | r_rshift;
    assign w_ctrl  = r_lctrl | r_rctrl;
    assign w_xl    = f_xlate(r_byte);
    assign w_upper = w_xl[16] ? (w_shift ^ r_caps) : w_shift;
    assign w_glyph = w_upper ? w_xl[7:0] : w_xl[15:8];
    assign w_char  = (w_ctrl && w_glyph[7:6] == 2'b01) ? {3'b000, w_glyph[4:0]} : w_glyph;

    // Prefix FSM: classifies each byte as prefix, ignored, or a (extended) make/break event.
    always_comb begin
        w_state_d = r_state;
        w_skip_d  = r_skip;
        w_evt     = 1'b0;
        w_ext     = 1'b0;
        w_brk     = 1'b0;
        if (w_take) begin
            case (r_state)
                StIdle: begin
                    case (r_byte)
                        8'hE0: w_state_d = StExt;
                        8'hF0: w_state_d = StBrk;
                        8'hE1: begin
                            w_state_d = StSkip;
                            w_skip_d  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: w_state_d = StIdle;
                        default: w_evt = 1'b1;
                    endcase
                end
                StExt: begin
                    if (r_byte == 8'hF0) begin
                        w_state_d = StExtBrk;
                    end else begin
                        w_evt     = 1'b1;
                        w_ext     = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                StBrk: begin
                    w_evt     = 1'b1;
                    w_brk     = 1'b1;
                    w_state_d = StIdle;
                end
                StExtBrk: begin
                    w_evt     = 1'b1;
                    w_ext     = 1'b1;
                    w_brk     = 1'b1;
                    w_state_d = StIdle;
                end
                StSkip: begin
                    w_skip_d = r_skip - 3'd1;
                    if (r_skip == 3'd1) w_state_d = StIdle;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_lshift_d    = r_lshift;
        w_rshift_d    = r_rshift;
        w_lctrl_d     = r_lctrl;
        w_rctrl_d     = r_rctrl;
        w_caps_d      = r_caps;
        w_caps_held_d = r_caps_held;
        w_push        = 1'b0;
        w_push_data   = 8'h00;
        w_ovf_set     = 1'b0;
`ifdef PS2_KBD_ARROW_EN
        w_seq_cnt_d   = r_seq_cnt;
        w_seq_last_d  = r_seq_last;
        if (r_seq_cnt != 2'd0) begin
            w_push      = 1'b1;
            w_push_data = (r_seq_cnt == 2'd2) ? 8'h5B : r_seq_last;
            w_seq_cnt_d = r_seq_cnt - 2'd1;
        end
`endif
        if (w_evt && !w_ext) begin
            case (r_byte)
                8'h12: w_lshift_d = ~w_brk;
                8'h59: w_rshift_d = ~w_brk;
                8'h14: w_lctrl_d  = ~w_brk;
                8'h58: begin
                    // Only the first make after a release toggles, so typematic repeats are inert.
                    if (w_brk) begin
                        w_caps_held_d = 1'b0;
                    end else if (!r_caps_held) begin
                        w_caps_d      = ~r_caps;
                        w_caps_held_d = 1'b1;
                    end
                end
                default: begin
                    w_push      = ~w_brk & w_xl[17];
                    w_push_data = w_char;
                end
            endcase
        end else if (w_evt) begin
            case (r_byte)
                8'h14: w_rctrl_d = ~w_brk;
                8'h5A: begin
                    w_push      = ~w_brk;
                    w_push_data = 8'h0D;
                end
`ifdef PS2_KBD_ARROW_EN
                8'h75, 8'h72, 8'h74, 8'h6B: begin
                    if (!w_brk && (DEPTH_W - w_count) >= SEQ_LEN) begin
                        w_push       = 1'b1;
                        w_push_data  = 8'h1B;
                        w_seq_cnt_d  = 2'd2;
                        w_seq_last_d = (r_byte == 8'h75) ? 8'h41 :
                                       (r_byte == 8'h72) ? 8'h42 :
                                       (r_byte == 8'h74) ? 8'h43 : 8'h44;
                    end else if (!w_brk) begin
                        w_ovf_set = 1'b1;
                    end
                end
`endif
                default: w_push = 1'b0;
            endcase
        end
    end

    assign w_count = r_wptr - r_rptr;
    assign w_valid = (r_wptr != r_rptr);
    assign w_full  = (w_count == DEPTH_W);
    assign w_pop   = w_valid & bus.key_ready;
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_done   <= 1'b0;
            r_byte_vld  <= 1'b0;
            r_byte      <= 8'h00;
            r_state     <= StIdle;
            r_skip      <= 3'd0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_rx_done <= bus.rx_done;
            // The captured byte is held while an escape sequence is still being pushed.
            if (bus.rx_done && !r_rx_done) begin
                r_byte     <= bus.rx_data;
                r_byte_vld <= 1'b1;
            end else if (w_take) begin
                r_byte_vld <= 1'b0;
            end
            r_state     <= w_state_d;
            r_skip      <= w_skip_d;
            r_lshift    <= w_lshift_d;
            r_rshift    <= w_rshift_d;
            r_lctrl     <= w_lctrl_d;
            r_rctrl     <= w_rctrl_d;
            r_caps      <= w_caps_d;
            r_caps_held <= w_caps_held_d;
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= w_push_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_ovf_set || (w_push && w_full && !w_pop)) r_overflow <= 1'b1;
        end
    end

`ifdef PS2_KBD_ARROW_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_cnt  <= 2'd0;
            r_seq_last <= 8'h00;
        end else begin
            r_seq_cnt  <= w_seq_cnt_d;
            r_seq_last <= w_seq_last_d;
        end
    end
`endif

    assign bus.key_data  = r_mem[r_rptr[AW-1:0]];
    assign bus.key_valid = w_valid;
    assign bus.shift     = w_shift;
    assign bus.ctrl      = w_ctrl;
    assign bus.caps      = r_caps;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_ps2_kbd.sv
// Self-checking bench for ps2_kbd: scoreboard of expected characters against popped characters.
// Arrow-key expectations follow PS2_KBD_ARROW_EN as defined for the build.
module tb_ps2_kbd;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    ps2_kbd_if u_if ();

    ps2_kbd #(.FIFO_DEPTH(DEPTH)) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (u_if)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad = 0;
    int         n_vcyc = 0;
    int         rd_idx = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Record every accepted character and every cycle with a character on offer.
    always @(negedge clk) begin
        if (u_if.key_valid) n_vcyc = n_vcyc + 1;
        if (u_if.key_valid && u_if.key_ready) got_q.push_back(u_if.key_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        u_if.rx_done   = 1'b0;
        u_if.rx_data   = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic send(input logic [7:0] b, input int hold = 3);
        u_if.rx_data = b;
        u_if.rx_done = 1'b1;
        tick(hold);
        u_if.rx_done = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        logic [7:0] e, g;
        u_if.key_ready = 1'b0;
        do_reset();
        send(8'h12); send(8'h14); send(8'h58);
        repeat (5) send(8'h29);
        reset_n = 1'b0;
        tick(1);
        n_total++; if (u_if.key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", u_if.key_valid); end
        n_total++; if (u_if.key_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", u_if.key_data); end
        n_total++; if (u_if.shift !== 1'b0) begin n_bad++; $display("FAIL rst_shift: got %b want 0", u_if.shift); end
        n_total++; if (u_if.ctrl !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b want 0", u_if.ctrl); end
        n_total++; if (u_if.caps !== 1'b0) begin n_bad++; $display("FAIL rst_caps: got %b want 0", u_if.caps); end
        n_total++; if (u_if.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", u_if.overflow); end
        reset_n = 1'b1;
        tick(2);
        // A break prefix cut off by reset must not swallow the next make.
        u_if.key_ready = 1'b1;
        rd_idx = got_q.size();
        send(8'hF0);
        do_reset();
        exp_q.push_back(8'h61);
        send(8'h1C);
        tick(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL midrst_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL midrst_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_letter();
        logic [7:0] e, g;
        int         v0;
        do_reset();
        u_if.key_ready = 1'b1;
        rd_idx = got_q.size();
        v0 = n_vcyc;
        exp_q.push_back(8'h61);
        send(8'h1C); send(8'hF0); send(8'h1C);
        tick(4);
        n_total++; if (n_vcyc - v0 != 1) begin n_bad++; $display("FAIL letter_vcyc: got %0d want 1", n_vcyc - v0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL letter_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL letter_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_shift_ctrl();
        logic [7:0] e, g;
        do_reset();
        u_if.key_ready = 1'b1;
        rd_idx = got_q.size();
        send(8'h12);
        n_total++; if (u_if.shift !== 1'b1) begin n_bad++; $display("FAIL shift_on: got %b want 1", u_if.shift); end
        exp_q.push_back(8'h41);
        send(8'h1C); send(8'hF0); send(8'h1C);
        n_total++; if (u_if.shift !== 1'b1) begin n_bad++; $display("FAIL shift_hold: got %b want 1", u_if.shift); end
        send(8'hF0); send(8'h12);
        n_total++; if (u_if.shift !== 1'b0) begin n_bad++; $display("FAIL shift_off: got %b want 0", u_if.shift); end
        send(8'h59);
        exp_q.push_back(8'h5F);
        send(8'h4E); send(8'hF0); send(8'h59);
        send(8'h14);
        n_total++; if (u_if.ctrl !== 1'b1) begin n_bad++; $display("FAIL ctrl_on: got %b want 1", u_if.ctrl); end
        exp_q.push_back(8'h03);
        send(8'h21);
        send(8'hF0); send(8'h14);
        n_total++; if (u_if.ctrl !== 1'b0) begin n_bad++; $display("FAIL ctrl_off: got %b want 0", u_if.ctrl); end
        exp_q.push_back(8'h32);
        send(8'h1E);
        tick(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL shift_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL shift_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_caps();
        logic [7:0] e, g;
        do_reset();
        u_if.key_ready = 1'b1;
        rd_idx = got_q.size();
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        n_total++; if (u_if.caps !== 1'b1) begin n_bad++; $display("FAIL caps_on: got %b want 1", u_if.caps); end
        exp_q.push_back(8'h41);
        send(8'h1C);
        exp_q.push_back(8'h61);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        exp_q.push_back(8'h31);
        send(8'h16);
        exp_q.push_back(8'h21);
        send(8'h12); send(8'h16); send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        n_total++; if (u_if.caps !== 1'b0) begin n_bad++; $display("FAIL caps_off: got %b want 0", u_if.caps); end
        exp_q.push_back(8'h61);
        send(8'h1C);
        tick(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL caps_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL caps_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_overflow();
        logic [7:0] e, g;
        do_reset();
        u_if.key_ready = 1'b0;
        rd_idx = got_q.size();
        repeat (5) send(8'h29);
        n_total++; if (u_if.key_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b want 1", u_if.key_valid); end
        n_total++; if (u_if.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", u_if.overflow); end
        n_total++; if (u_if.key_data !== 8'h20) begin n_bad++; $display("FAIL ovf_head: got %h want 20", u_if.key_data); end
        repeat (DEPTH) exp_q.push_back(8'h20);
        u_if.key_ready = 1'b1;
        tick(8);
        n_total++; if (u_if.key_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", u_if.key_valid); end
        n_total++; if (u_if.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", u_if.overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL ovf_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_pause_ext();
        logic [7:0] e, g;
        logic [7:0] pause [8];
        pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        u_if.key_ready = 1'b1;
        rd_idx = got_q.size();
        for (int i = 0; i < 8; i++) send(pause[i]);
        send(8'hAA); send(8'hFA);
        n_total++; if (u_if.ctrl !== 1'b0) begin n_bad++; $display("FAIL pause_ctrl: got %b want 0", u_if.ctrl); end
        exp_q.push_back(8'h61);
        send(8'h1C);
        send(8'hE0); send(8'h14);
        n_total++; if (u_if.ctrl !== 1'b1) begin n_bad++; $display("FAIL rctrl_on: got %b want 1", u_if.ctrl); end
        send(8'hE0); send(8'hF0); send(8'h14);
        n_total++; if (u_if.ctrl !== 1'b0) begin n_bad++; $display("FAIL rctrl_off: got %b want 0", u_if.ctrl); end
        exp_q.push_back(8'h0D);
        send(8'hE0); send(8'h5A);
        exp_q.push_back(8'h08);
        send(8'h66);
        exp_q.push_back(8'h09);
        send(8'h0D);
        exp_q.push_back(8'h1B);
        send(8'h76);
        tick(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL pause_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL pause_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, g;
        int         v0;
        do_reset();
        u_if.key_ready = 1'b0;
        rd_idx = got_q.size();
        exp_q.push_back(8'h61); send(8'h1C, 8);
        exp_q.push_back(8'h62); send(8'h32, 8);
        exp_q.push_back(8'h63); send(8'h21, 8);
        v0 = n_vcyc;
        u_if.key_ready = 1'b1;
        tick(6);
        n_total++; if (n_vcyc - v0 != 3) begin n_bad++; $display("FAIL b2b_vcyc: got %0d want 3", n_vcyc - v0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL b2b_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    task automatic test_arrow();
        logic [7:0] e, g;
        logic       ovf_exp;
        do_reset();
        u_if.key_ready = 1'b1;
        rd_idx = got_q.size();
`ifdef PS2_KBD_ARROW_EN
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h41);
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        exp_q.push_back(8'h61);
        send(8'hE0);
        // Up arrow immediately followed by a letter whose rising edge lands mid-sequence.
        u_if.rx_data = 8'h75; u_if.rx_done = 1'b1; tick(1);
        u_if.rx_done = 1'b0; tick(1);
        u_if.rx_data = 8'h1C; u_if.rx_done = 1'b1; tick(2);
        u_if.rx_done = 1'b0; tick(6);
`ifdef PS2_KBD_ARROW_EN
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h44);
`endif
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h6B);
        u_if.key_ready = 1'b0;
        send(8'h29); send(8'h29);
        send(8'hE0); send(8'h72);
        n_total++; if (u_if.overflow !== ovf_exp) begin n_bad++; $display("FAIL arrow_ovf: got %b want %b", u_if.overflow, ovf_exp); end
        exp_q.push_back(8'h20); exp_q.push_back(8'h20);
        u_if.key_ready = 1'b1;
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            rd_idx++;
            n_total++; if (g !== e) begin n_bad++; $display("FAIL arrow_char: got %h want %h", g, e); end
        end
        n_total++; if (got_q.size() != rd_idx) begin n_bad++; $display("FAIL arrow_count: got %0d want %0d", got_q.size(), rd_idx); end
    endtask

    initial begin
        u_if.rx_data   = 8'h00;
        u_if.rx_done   = 1'b0;
        u_if.key_ready = 1'b0;
        test_reset();
        test_letter();
        test_shift_ctrl();
        test_caps();
        test_overflow();
        test_pause_ext();
        test_back_to_back();
        test_arrow();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
